// File: rtl/calendar_display_mux.sv
// rtl/calendar_display_mux.sv - Multiplexes calendar BCD digits onto a 4-digit 7-segment display, alternating MM.DD and CCYY pages.
// Optional feature macro: CAL_LZ_BLANK_EN (blank leading zero of month and day on the MM.DD page).
module calendar_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int DWELL_S     = 5
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       page_btn,
  input  logic [3:0] m_10s,
  input  logic [3:0] m_1s,
  input  logic [3:0] d_10s,
  input  logic [3:0] d_1s,
  input  logic [3:0] y_10s,
  input  logic [3:0] y_1s,
  input  logic [3:0] c_10s,
  input  logic [3:0] c_1s,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       page_cy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = (DWELL_S > 1) ? $clog2(DWELL_S) : 1;

  typedef enum logic {PG_MD = 1'b0, PG_CY = 1'b1} page_t;

  page_t          page_req, page_nxt, page_shown, eff_page;
  logic [2:0]     tick_sync, btn_sync;
  logic           tick_pulse, btn_pulse;
  logic [RW-1:0]  ref_cnt;
  logic [1:0]     idx;
  logic [DW-1:0]  dwell, dwell_nxt;
  logic [31:0]    live, shadow, eff;
  logic           frame_start;
  logic [3:0]     nib;
  logic           lz_blank;
  logic [6:0]     seg_nxt;
  logic           dp_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'h7F;
    endcase
  endfunction

  assign tick_pulse  = tick_sync[1] & ~tick_sync[2];
  assign btn_pulse   = btn_sync[1] & ~btn_sync[2];
  assign frame_start = (ref_cnt == '0) && (idx == 2'd3);
  assign live        = {m_10s, m_1s, d_10s, d_1s, c_10s, c_1s, y_10s, y_1s};

  // On the capture cycle the output stage looks at the values being captured,
  // so the first slot of a frame already shows the new frame's content.
  assign eff      = frame_start ? live : shadow;
  assign eff_page = frame_start ? page_req : page_shown;

  always_comb begin
    page_nxt  = page_req;
    dwell_nxt = dwell;
    if (btn_pulse || (tick_pulse && dwell == DW'(DWELL_S - 1))) begin
      page_nxt  = (page_req == PG_MD) ? PG_CY : PG_MD;
      dwell_nxt = '0;
    end else if (tick_pulse) begin
      dwell_nxt = dwell + 1'b1;
    end
  end

  always_comb begin
    nib      = '0;
    lz_blank = 1'b0;
    dp_nxt   = 1'b1;
    if (eff_page == PG_CY) begin
      nib = eff[{idx, 2'b00} +: 4];
    end else begin
      nib    = eff[{idx, 2'b00} + 5'd16 +: 4];
      dp_nxt = (idx != 2'd2);
`ifdef CAL_LZ_BLANK_EN
      lz_blank = idx[0] && (nib == 4'd0);
`endif
    end
    seg_nxt = lz_blank ? 7'h7F : bcd_to_seg(nib);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      page_req <= PG_MD;
      dwell    <= '0;
    end else begin
      page_req <= page_nxt;
      dwell    <= dwell_nxt;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tick_sync  <= 3'b000;
      btn_sync   <= 3'b000;
      ref_cnt    <= '0;
      idx        <= 2'd3;
      page_shown <= PG_MD;
      shadow     <= '0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= 4'b1111;
      page_cy    <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[1:0], tick_1Hz};
      btn_sync  <= {btn_sync[1:0], page_btn};
      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= idx - 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (frame_start) begin
        shadow     <= live;
        page_shown <= page_req;
      end
      seg     <= seg_nxt;
      dp      <= dp_nxt;
      an      <= ~(4'b0001 << idx);
      page_cy <= (eff_page == PG_CY);
    end
  end

endmodule

// File: tb/tb_calendar_display_mux.sv
// tb/tb_calendar_display_mux.sv - Self-checking bench for calendar_display_mux: cycle model plus directed literal checks.
module tb_calendar_display_mux;

  localparam int DIV   = 4;
  localparam int DWELL = 3;

  logic clk_100MHz = 1'b0;
  logic reset = 1'b1;
  logic tick_1Hz = 1'b0, page_btn = 1'b0;
  logic [3:0] m_10s = 4'd1, m_1s = 4'd2, d_10s = 4'd2, d_1s = 4'd0;
  logic [3:0] y_10s = 4'd2, y_1s = 4'd4, c_10s = 4'd2, c_1s = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       page_cy;

  int n_checks = 0;
  int n_fail   = 0;

  calendar_display_mux #(.REFRESH_DIV(DIV), .DWELL_S(DWELL)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz), .page_btn(page_btn),
    .m_10s(m_10s), .m_1s(m_1s), .d_10s(d_10s), .d_1s(d_1s),
    .y_10s(y_10s), .y_1s(y_1s), .c_10s(c_10s), .c_1s(c_1s),
    .seg(seg), .dp(dp), .an(an), .page_cy(page_cy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, frame snapshot per page, page request with dwell count.
  int unsigned m_cnt;
  logic [15:0] m_md, m_cy;
  logic        m_fpage, m_req;
  int          m_dwell;
  logic [2:0]  m_th, m_bh;
  wire m_tp = m_th[1] & ~m_th[2];
  wire m_bp = m_bh[1] & ~m_bh[2];

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_md <= '0; m_cy <= '0; m_fpage <= 1'b0; m_req <= 1'b0;
      m_dwell <= 0; m_th <= '0; m_bh <= '0;
    end else begin
      if (m_cnt % (4 * DIV) == 0) begin
        m_md    <= {m_10s, m_1s, d_10s, d_1s};
        m_cy    <= {c_10s, c_1s, y_10s, y_1s};
        m_fpage <= m_req;
      end
      m_cnt <= m_cnt + 1;
      m_th  <= {m_th[1:0], tick_1Hz};
      m_bh  <= {m_bh[1:0], page_btn};
      if (m_bp || (m_tp && m_dwell == DWELL - 1)) begin
        m_req   <= ~m_req;
        m_dwell <= 0;
      end else if (m_tp) begin
        m_dwell <= m_dwell + 1;
      end
    end
  end

  always @(negedge clk_100MHz) begin
    int pos, di;
    logic [3:0] d;
    logic blank;
    if (m_cnt == 0) begin
      chk("cmp_an_blank", an, 4'b1111);
      chk("cmp_seg_blank", seg, 7'h7F);
      chk("cmp_dp_blank", dp, 1);
      chk("cmp_page_rst", page_cy, 0);
    end else begin
      pos = int'(m_cnt) - 1;
      di  = 3 - ((pos / DIV) % 4);
      d   = m_fpage ? m_cy[di*4 +: 4] : m_md[di*4 +: 4];
      blank = 1'b0;
`ifdef CAL_LZ_BLANK_EN
      blank = !m_fpage && (di == 3 || di == 1) && d == 4'd0;
`endif
      chk("cmp_an", an, 4'b1111 & ~(4'b0001 << di));
      chk("cmp_seg", seg, blank ? 7'h7F : seg_tab[d]);
      chk("cmp_dp", dp, (!m_fpage && di == 2) ? 0 : 1);
      chk("cmp_page", page_cy, m_fpage);
    end
  end

  task automatic wait_an(input logic [3:0] v, input bit fresh, input string nm);
    int k = 0;
    @(negedge clk_100MHz);
    if (fresh) while (an == v && k < 40) begin @(negedge clk_100MHz); k++; end
    while (an != v && k < 80) begin @(negedge clk_100MHz); k++; end
    if (an != v) chk({nm, "_timeout"}, an, v);
  endtask

  task automatic wait_page(input logic v, input string nm);
    int k = 0;
    while (page_cy != v && k < 60) begin @(negedge clk_100MHz); k++; end
    chk(nm, page_cy, v);
  endtask

  task automatic pulse(input bit t, input bit b);
    @(negedge clk_100MHz);
    tick_1Hz = t; page_btn = b;
    repeat (2) @(negedge clk_100MHz);
    tick_1Hz = 1'b0; page_btn = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  logic [3:0] an_l  [4];
  logic [6:0] md_l  [4];
  logic [6:0] cy_l  [4];
  logic       dpl   [4];

  initial begin
    an_l[0] = 4'b0111; an_l[1] = 4'b1011; an_l[2] = 4'b1101; an_l[3] = 4'b1110;
    md_l[0] = 7'b1111001; md_l[1] = 7'b0100100; md_l[2] = 7'b0100100; md_l[3] = 7'b1000000;
    cy_l[0] = 7'b0100100; cy_l[1] = 7'b1000000; cy_l[2] = 7'b0100100; cy_l[3] = 7'b0011001;
    dpl[0] = 1'b1; dpl[1] = 1'b0; dpl[2] = 1'b1; dpl[3] = 1'b1;

    repeat (3) @(negedge clk_100MHz);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_page", page_cy, 0);
    reset = 1'b0;

    // M=12 D=20 scan
    for (int i = 0; i < 4; i++) begin
      wait_an(an_l[i], 1'b0, "md_scan");
      chk("md_seg", seg, md_l[i]);
      chk("md_dp", dp, dpl[i]);
    end

    // three ticks rotate to CCYY (C=20 Y=24)
    repeat (3) pulse(1'b1, 1'b0);
    wait_page(1'b1, "auto_rotate");
    for (int i = 0; i < 4; i++) begin
      wait_an(an_l[i], 1'b0, "cy_scan");
      chk("cy_seg", seg, cy_l[i]);
      chk("cy_dp", dp, 1);
    end

    // button coincident with third tick: one toggle, dwell restarts
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b1, 1'b1);
    repeat (40) @(negedge clk_100MHz);
    chk("coincident_one_toggle", page_cy, 0);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    repeat (40) @(negedge clk_100MHz);
    chk("dwell_cleared", page_cy, 0);
    pulse(1'b1, 1'b0);
    wait_page(1'b1, "rotate_after_3");

    // mid-frame input change is held off until the next frame
    pulse(1'b0, 1'b1);
    wait_page(1'b0, "btn_to_md");
    wait_an(4'b1011, 1'b1, "midframe");
    d_1s = 4'd1;
    wait_an(4'b1110, 1'b0, "midframe_idx0");
    chk("no_tear", seg, 7'b1000000);
    wait_an(4'b1110, 1'b1, "next_frame_idx0");
    chk("next_frame", seg, 7'b1111001);

    // non-BCD digit blanks
    y_1s = 4'hA;
    pulse(1'b0, 1'b1);
    wait_page(1'b1, "btn_to_cy");
    wait_an(4'b1110, 1'b1, "cy_idx0");
    chk("code_A_blank", seg, 7'h7F);

    // leading zeros: M=01 D=05
    m_10s = 4'd0; m_1s = 4'd1; d_10s = 4'd0; d_1s = 4'd5;
    pulse(1'b0, 1'b1);
    wait_page(1'b0, "btn_to_md2");
    wait_an(4'b0111, 1'b1, "lz_idx3");
`ifdef CAL_LZ_BLANK_EN
    chk("lz_idx3", seg, 7'h7F);
`else
    chk("lz_idx3", seg, 7'b1000000);
`endif
    wait_an(4'b1101, 1'b0, "lz_idx1");
`ifdef CAL_LZ_BLANK_EN
    chk("lz_idx1", seg, 7'h7F);
`else
    chk("lz_idx1", seg, 7'b1000000);
`endif

    // reset mid-frame blanks at once and restarts at idx3
    wait_an(4'b1011, 1'b1, "pre_reset");
    #2 reset = 1'b1;
    #1;
    chk("midrst_an", an, 4'b1111);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1);
    chk("midrst_page", page_cy, 0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    @(negedge clk_100MHz);
    chk("restart_an", an, 4'b0111);
    chk("restart_seg", seg, 7'b1000000);
    repeat (40) @(negedge clk_100MHz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
